// File: rtl/sc_outbus_bcd_pkg.sv
// Shared types and constants for the output-bus BCD display block:
// conversion FSM states, blank pattern and active-low digit glyphs.
package sc_outbus_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry d (0..9) holds the glyph for decimal digit d.
    localparam logic [9:0][6:0] SEG_PAT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/sc_bcd7seg.sv
// BCD digit to active-low 7-segment decoder with blank override.
// Ports: digit (4-bit BCD), blank (force off), seg ({g..a}, active-low).
module sc_bcd7seg
    import sc_outbus_bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Codes 10..15 cannot come out of the converter; show nothing.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank && digit <= 4'd9) begin
            seg = SEG_PAT[digit];
        end
    end

endmodule

// File: rtl/sc_outbus_bcd.sv
// Converts each new datapath bus value to packed BCD (double dabble)
// and scans it onto a multiplexed active-low 7-segment display.
// Ports: clock, async active-low reset, data bus in, BCD bus out,
// valid pulse, busy flag, segments {g..a} and one-hot anodes (active-low).
module sc_outbus_bcd
    import sc_outbus_bcd_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 16,
    parameter int DIGITS        = 5,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_ZEROS   = 1
) (
    input  logic                       sc_outbus_bcd_CLOCK_50,
    input  logic                       sc_outbus_bcd_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0]   sc_outbus_bcd_data_InBUS,
    output logic [4*DIGITS-1:0]        sc_outbus_bcd_bcd_OutBUS,
    output logic                       sc_outbus_bcd_valid_OutHigh,
    output logic                       sc_outbus_bcd_busy_OutHigh,
    output logic [6:0]                 sc_outbus_bcd_segments_OutLow,
    output logic [DIGITS-1:0]          sc_outbus_bcd_anodes_OutLow
);

    localparam int DW = DATAWIDTH_BUS;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATAWIDTH_BUS + 1);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic clk;
    logic rst_n;
    assign clk   = sc_outbus_bcd_CLOCK_50;
    assign rst_n = sc_outbus_bcd_RESET_InLow;

    state_t          state;
    state_t          state_next;
    logic            start;
    logic [DW-1:0]   captured;
    logic [DW-1:0]   bin;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   adjusted;
    logic [BW-1:0]   bcd;
    logic [CW-1:0]   cnt;
    logic            valid;
    logic            busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sc_outbus_bcd_data_InBUS != captured) begin
                    start      = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == CW'(DW - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Double-dabble correction applied before each shift.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured <= '0;
            bin      <= '0;
            scratch  <= '0;
            cnt      <= '0;
            bcd      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        captured <= sc_outbus_bcd_data_InBUS;
                        bin      <= sc_outbus_bcd_data_InBUS;
                        scratch  <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    scratch <= {adjusted[BW-2:0], bin[DW-1]};
                    bin     <= {bin[DW-2:0], 1'b0};
                    cnt     <= cnt + CW'(1);
                end
                ST_DONE: begin
                    bcd   <= scratch;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Leading-zero run scanned from the top digit down; digit 0 never blanks.
    logic [DIGITS-1:0] blank;
    logic              lz;

    always_comb begin
        blank = '0;
        lz    = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz       = lz & (bcd[4*i +: 4] == 4'd0);
            blank[i] = lz & (BLANK_ZEROS != 0);
        end
    end

    logic [3:0]        cur_digit;
    logic              cur_blank;
    logic [DIGITS-1:0] anodes_next;
    logic [6:0]        seg_next;

    always_comb begin
        cur_digit   = '0;
        cur_blank   = 1'b0;
        anodes_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit      = bcd[4*i +: 4];
                cur_blank      = blank[i];
                anodes_next[i] = 1'b0;
            end
        end
    end

    sc_bcd7seg u_dec (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg_next)
    );

    logic [6:0]        seg_q;
    logic [DIGITS-1:0] anodes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= SEG_BLANK;
            anodes_q <= '1;
        end else begin
            seg_q    <= seg_next;
            anodes_q <= anodes_next;
        end
    end

    assign sc_outbus_bcd_bcd_OutBUS      = bcd;
    assign sc_outbus_bcd_valid_OutHigh   = valid;
    assign sc_outbus_bcd_busy_OutHigh    = busy;
    assign sc_outbus_bcd_segments_OutLow = seg_q;
    assign sc_outbus_bcd_anodes_OutLow   = anodes_q;

endmodule
